// File: rtl/mac_neuron_unit_pkg.sv
// Shared NN definitions: default operand/vector/accumulator sizing and the
// neuron controller state encoding.
package mac_neuron_unit_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_VEC_LEN    = 4;
  localparam int ACC_GUARD_BITS = 4;
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + ACC_GUARD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/mac_neuron_unit_mult.sv
// Stage 1 of the neuron pipeline: registers the full-precision signed product
// of one accepted activation/weight pair.
module mac_mult_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   act,
  input  logic signed [DATA_WIDTH-1:0]   weight,
  output logic signed [2*DATA_WIDTH-1:0] prod,
  output logic                           prod_valid
);

  logic signed [2*DATA_WIDTH-1:0] mul;

  assign mul = act * weight;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) prod <= mul;
    end
  end

endmodule

// File: rtl/mac_neuron_unit.sv
// Single neuron: streams VEC_LEN signed pairs, accumulates their dot product and
// presents it (optionally ReLU'd) behind a held valid/ready output.
module mac_neuron_unit
  import mac_neuron_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VEC_LEN    = DEF_VEC_LEN,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ACC_GUARD_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2*DATA_WIDTH-1:0]      data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         relu_en,
  output logic [ACC_WIDTH-1:0]         result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(VEC_LEN+1)-1:0] elem_count,
  output state_t                       fsm_state
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int PW    = 2 * DATA_WIDTH;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and out_valid/result hold until transferred.
  state_t                  state_q, state_d;
  logic                    flush_q;
  logic                    accept, last_accept, handshake, load_result;
  logic [CNT_W-1:0]        elem_count_q;
  logic signed [PW-1:0]    prod;
  logic                    prod_valid;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_q, result_q;
  logic                    out_valid_q, relu_sel_q;

  assign in_ready    = (state_q == ST_ACCUM) && enable;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (elem_count_q == CNT_W'(VEC_LEN - 1));
  assign handshake   = out_valid_q && out_ready;
  // First OUTPUT cycle captures the settled accumulator into the result register.
  assign load_result = (state_q == ST_OUTPUT) && !out_valid_q;
  assign prod_ext    = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

  assign result     = result_q;
  assign out_valid  = out_valid_q;
  assign elem_count = elem_count_q;
  assign fsm_state  = state_q;

  mac_mult_stage #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (accept),
    .act        (data_in[2*DATA_WIDTH-1:DATA_WIDTH]),
    .weight     (data_in[DATA_WIDTH-1:0]),
    .prod       (prod),
    .prod_valid (prod_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACCUM;
      ST_ACCUM:  if (last_accept) state_d = ST_FLUSH;
      ST_FLUSH:  if (flush_q) state_d = ST_OUTPUT;
      ST_OUTPUT: if (handshake) state_d = enable ? ST_ACCUM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_q == ST_FLUSH) && !flush_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      elem_count_q <= '0;
      relu_sel_q   <= 1'b0;
      acc_q        <= '0;
      result_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (accept)         elem_count_q <= elem_count_q + CNT_W'(1);
      else if (handshake) elem_count_q <= '0;

      if (last_accept) relu_sel_q <= relu_en;

      if (handshake)       acc_q <= '0;
      else if (prod_valid) acc_q <= acc_q + prod_ext;

      if (load_result) begin
        result_q    <= (relu_sel_q && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_neuron_unit.md
MAC_NEURON_UNIT -- requirements
Module: mac_neuron_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the width of one signed two's-complement operand.
REQ-002 The module SHALL have parameter VEC_LEN, default 4, giving the number of activation/weight pairs per dot product; legal values are 2..64.
REQ-003 The module SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+4, giving the width of the signed accumulator; it must be at least 2*DATA_WIDTH+clog2(VEC_LEN).
REQ-004 The module SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: global run enable, the same signal that drives the controller and the input register bank.
REQ-008 Port data_in, input, 2*DATA_WIDTH bits: bits [2W-1:W] are the signed activation and bits [W-1:0] are the signed weight.
REQ-009 Port in_valid, input, 1 bit: data_in carries a valid pair this cycle.
REQ-010 Port in_ready, output, 1 bit: the module accepts a pair this cycle.
REQ-011 Port relu_en, input, 1 bit: applies ReLU to the result; it is sampled when the final pair is accepted.
REQ-012 Port result, output, ACC_WIDTH bits: the signed dot product, after ReLU when relu_en is set.
REQ-013 Port out_valid, output, 1 bit: result is valid.
REQ-014 Port out_ready, input, 1 bit: the consumer takes result this cycle.
REQ-015 Port elem_count, output, clog2(VEC_LEN+1) bits: number of pairs accepted into the current dot product.

Function
REQ-016 The FSM SHALL have four states: IDLE, ACCUM, FLUSH and OUTPUT.
REQ-017 Transition IDLE->ACCUM SHALL occur when enable=1.
REQ-018 Transition ACCUM->FLUSH SHALL occur on the VEC_LEN-th accepted pair.
REQ-019 FLUSH SHALL last exactly 2 cycles and then move to OUTPUT.
REQ-020 Transition OUTPUT->ACCUM SHALL occur on an out_valid&out_ready handshake when enable=1; if enable=0 the transition SHALL be to IDLE.
REQ-021 in_ready SHALL equal (state==ACCUM && enable); a pair is accepted on a cycle where in_valid&in_ready=1.
REQ-022 Pipeline stage 1 SHALL register the full-precision signed product of the accepted pair (2*DATA_WIDTH bits).
REQ-023 Pipeline stage 2 SHALL add the sign-extended product into the ACC_WIDTH accumulator.
REQ-024 Stage 3 SHALL register result, equal to max(acc,0) when relu_en=1, otherwise acc.
REQ-025 Latency: when the final pair is accepted at edge t, out_valid SHALL rise after edge t+3 and result SHALL be stable from that same cycle.
REQ-026 In OUTPUT, out_valid and result SHALL be held unchanged until the handshake, and in_ready SHALL be 0 (backpressure).
REQ-027 On the handshake, the accumulator and elem_count SHALL clear in the same edge, so that no partial sum leaks into the next dot product.
REQ-028 With enable=0 during ACCUM, in_ready=0 and the partial sum and elem_count SHALL be held; accumulation resumes when enable returns to 1.
REQ-029 Gaps in in_valid SHALL be tolerated without adding bubbles to the sum: only accepted pairs count.
REQ-030 The accumulator SHALL never wrap for legal parameters; no saturation logic is required.
REQ-031 Worst case (-2^(W-1))^2 * VEC_LEN SHALL fit in ACC_WIDTH as a positive value.
REQ-032 elem_count SHALL increment on each accepted pair, hold during FLUSH and OUTPUT, and clear on the handshake.

Reset
REQ-033 reset=1 SHALL force state=IDLE, accumulator=0, elem_count=0, result=0, out_valid=0, in_ready=0 and clear both pipeline registers.
REQ-034 reset SHALL take priority over every other input.
REQ-035 Reset asserted mid-operation (ACCUM, FLUSH or OUTPUT) SHALL discard the partial sum, and the next dot product SHALL start from zero.

Structure
REQ-036 DATA_WIDTH, VEC_LEN and ACC_WIDTH defaults, plus the FSM state encodings, SHALL reside in the shared NN definitions header used by the ROM, controller and input register bank.
REQ-037 The signed multiply plus product register SHALL be a sub-module named mac_mult_stage.
REQ-038 The FSM, accumulator and ReLU/output register SHALL reside in mac_neuron_unit.

Verification
REQ-039 The bench SHALL cover: activations 1,2,3,4 and weights 5,6,7,8, relu_en=0, in_valid continuous -> result=70 (0x00046) with out_valid 3 cycles after the last accept.
REQ-040 The bench SHALL cover: activations -1,-2,-3,-4 and weights 1,1,1,1 -> relu_en=0 gives result=-10 (0xFFFF6); relu_en=1 gives result=0.
REQ-041 The bench SHALL cover: all pairs (-128,-128), relu_en=0 -> result=65536 (0x10000), with no wrap.
REQ-042 The bench SHALL cover: out_ready held low for 5 cycles in OUTPUT -> result and out_valid stable, in_ready=0; after the handshake the next vector 1,1,1,1 x 1,1,1,1 gives result=4.
REQ-043 The bench SHALL cover: enable low for 3 cycles after the 2nd pair plus in_valid gaps -> the final result equals the uninterrupted sum and elem_count reaches 4.
REQ-044 The bench SHALL cover: reset asserted after the 3rd pair -> all outputs 0 and state IDLE on the next cycle; a fresh vector 1,2,3,4 x 5,6,7,8 then gives 70.
